// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

  // Buffer state: StIdle while the remaining-keep mask is empty, StSend otherwise.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } stream_state_e;

  // Bits needed to index one narrow lane of a wide beat.
  function automatic int unsigned lane_idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Index of the lowest set bit of a mask, plus a flag for "exactly one bit set".
module lowest_set_idx
  import stream_pkg::*;
#(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0]                  i_mask,
  output logic [lane_idx_width(Width)-1:0]  o_idx,
  output logic                              o_one_hot
);

  localparam int unsigned IdxW = lane_idx_width(Width);

  // Scan from the top so the lowest set bit wins; empty mask yields index 0.
  always_comb begin
    o_idx = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IdxW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves nothing only when a single bit was set.
  assign o_one_hot = (i_mask != '0) && ((i_mask & (i_mask - Width'(1))) == '0);

endmodule

// File: rtl/stream_downsize.sv
// Splits each wide beat into its kept narrow lanes, lowest lane first.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 1,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  localparam int unsigned IdxW = lane_idx_width(T_DATA_RATIO);

  stream_state_e                            r_state;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_data;
  logic [T_DATA_RATIO-1:0]                   r_mask;
  logic                                      r_last;

  logic [IdxW-1:0]         w_idx;
  logic                    w_one_hot;
  logic                    w_send;
  logic                    w_m_fire;
  logic                    w_s_fire;
  logic [T_DATA_RATIO-1:0] w_mask_rest;

  lowest_set_idx #(
    .Width (T_DATA_RATIO)
  ) u_lowest_set_idx (
    .i_mask    (r_mask),
    .o_idx     (w_idx),
    .o_one_hot (w_one_hot)
  );

  assign w_send   = (r_state == StSend);
  assign w_m_fire = w_send && m_ready_i;

  // Refill when empty, or in the same cycle the final kept lane leaves, so
  // full-keep streams run without bubbles. Held low while reset is asserted.
  assign s_ready_o = !rst_n && (!w_send || (w_m_fire && w_one_hot));
  assign w_s_fire  = s_valid_i && s_ready_o;

  // Remaining mask with the current (lowest) lane removed.
  assign w_mask_rest = r_mask & (r_mask - T_DATA_RATIO'(1));

  // The lane currently offered is the highest kept one when it is the only bit left.
  assign m_valid_o = w_send;
  assign m_data_o  = r_data[w_idx];
  assign m_last_o  = w_send && w_one_hot && r_last;

  // Buffer/FSM update: load a new wide beat or retire the current narrow lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
    end else if (w_s_fire) begin
      r_data  <= s_data_i;
      r_mask  <= s_keep_i;
      r_last  <= s_last_i;
      // An all-zero keep beat is swallowed: nothing to send, stay idle.
      r_state <= (s_keep_i != '0) ? StSend : StIdle;
    end else if (w_m_fire) begin
      r_mask <= w_mask_rest;
      if (w_one_hot) begin
        r_state <= StIdle;
      end
    end
  end

endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 1, meaning width of one narrow lane in bits.
REQ-002 SHALL have parameter T_DATA_RATIO, default 2, meaning number of narrow lanes per wide input beat (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-high (one clock; reset synchronous and active-high).
REQ-005 SHALL have port s_data_i  input  [T_DATA_WIDTH-1:0] x [T_DATA_RATIO-1:0]  wide beat; lane 0 is the first in stream order.
REQ-006 SHALL have port s_keep_i  input  T_DATA_RATIO  per-lane valid mask.
REQ-007 SHALL have port s_last_i  input  1  wide beat ends the packet.
REQ-008 SHALL have port s_valid_i  input  1  wide beat present.
REQ-009 SHALL have port s_ready_o  output  1  wide beat accepted when s_valid_i && s_ready_o.
REQ-010 SHALL have port m_data_o  output  T_DATA_WIDTH  narrow lane data.
REQ-011 SHALL have port m_last_o  output  1  final narrow beat of the packet.
REQ-012 SHALL have port m_valid_o  output  1  narrow beat present.
REQ-013 SHALL have port m_ready_i  input  1  narrow beat consumed when m_valid_o && m_ready_i.

Function
REQ-014 SHALL hold one wide beat in a buffer: lane data, a remaining-keep mask and a last flag; state IDLE (mask empty) or SEND (mask non-zero).
REQ-015 SHALL drive s_ready_o = IDLE || (m_valid_o && m_ready_i && exactly one bit left in the remaining mask), combinationally from registered state and m_ready_i.
REQ-016 SHALL, on s_valid_i && s_ready_o, load s_data_i, s_keep_i and s_last_i into the buffer; the first narrow beat is valid the next cycle (latency 1).
REQ-017 SHALL emit kept lanes in ascending index order, skipping lanes whose keep bit is 0; the current lane is the lowest set bit of the remaining mask.
REQ-018 SHALL drive m_valid_o = SEND, and m_data_o = buffer lane at the current index.
REQ-019 SHALL assert m_last_o only while the current lane is the highest kept lane and the buffered last flag is 1.
REQ-020 SHALL, on m_valid_o && m_ready_i, clear the current lane's bit; if the mask becomes empty and no new beat is accepted, the block enters IDLE.
REQ-021 SHALL, when the final kept lane handshakes in the same cycle as a wide beat is accepted, load the new beat with no idle cycle, so full-keep streams sustain 1 narrow beat/cycle.
REQ-022 SHALL hold m_data_o, m_last_o and m_valid_o stable while m_valid_o && !m_ready_i (no retraction).
REQ-023 SHALL discard an accepted beat with s_keep_i == 0 and emit nothing for it; its s_last_i is dropped (upstream shall not send all-zero last beats).
REQ-024 SHALL support non-contiguous keep patterns (e.g. 4'b1010 emits lane 1 then lane 3).

Reset
REQ-025 SHALL, while rst_n is 1 at a clock edge, clear the buffer data to 0, the mask to 0 and the last flag to 0.
REQ-026 SHALL give reset values m_valid_o=0, m_last_o=0, m_data_o=0, and s_ready_o=0 while rst_n is high; s_ready_o=1 in the first cycle after release.
REQ-027 SHALL abandon a partially sent beat on reset mid-operation; no stale lane is emitted afterwards.

Structure
REQ-028 SHALL place the state enum typedef (IDLE/SEND) and the lane-index width function ($clog2(T_DATA_RATIO)) in shared package stream_pkg.
REQ-029 SHALL implement lowest-set-bit selection in sub-module lowest_set_idx (mask in, index plus one-hot-remaining flag out).

Verification (T_DATA_WIDTH=8, T_DATA_RATIO=4)
REQ-030 Beat {D3..D0}={44,33,22,11}, keep=4'b1111, last=1, m_ready_i=1 -> m_data_o 11,22,33,44 on four consecutive cycles, m_last_o only with 44, s_ready_o=1 in the cycle 44 is emitted.
REQ-031 Two back-to-back full-keep beats, m_ready_i=1 -> 8 narrow beats on 8 consecutive cycles, no bubble, s_valid_i held -> second beat accepted on the cycle of the first beat's lane 3.
REQ-032 keep=4'b1010, data {DD,CC,BB,AA}, last=1 -> outputs BB then DD, m_last_o with DD only.
REQ-033 m_ready_i toggling 1,0,0,1 during a full beat -> m_data_o/m_valid_o/m_last_o stable during the low cycles, no lane lost or duplicated.
REQ-034 keep=4'b0000 beat followed by keep=4'b0001 beat data 5A -> only 5A emitted.
REQ-035 rst_n pulsed high after two lanes of a four-lane beat -> m_valid_o=0 the next cycle, s_ready_o=1 after release, next beat emitted from its lane 0.
